// File: rtl/mem_bus_if_pkg.sv
// Shared CPU/bus definitions for the memory bus interface: FSM states,
// strobe polarities, access direction and scratchpad address decode.
package mem_bus_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCESS,
    ST_STALL
  } bus_state_t;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned SPM_TAG_MSB  = 29;
  localparam int unsigned SPM_TAG_LSB  = 27;
  localparam logic [2:0]  SPM_ADDR_TAG = 3'b011;

  function automatic logic spm_hit(input logic [29:0] a);
    return a[SPM_TAG_MSB:SPM_TAG_LSB] == SPM_ADDR_TAG;
  endfunction

endpackage

// File: rtl/mem_bus_if_if.sv
// Shared-bus master port bundle; strobes, request, grant and ready are active-low.
interface mem_bus_if_if;
  logic [31:0] bus_rd_data;
  logic        bus_rdy_;
  logic        bus_grnt_;
  logic        bus_req_;
  logic [29:0] bus_addr;
  logic        bus_as_;
  logic        bus_rw;
  logic [31:0] bus_wr_data;

  modport master (
    input  bus_rd_data, bus_rdy_, bus_grnt_,
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );

  modport slave (
    output bus_rd_data, bus_rdy_, bus_grnt_,
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
  );
endinterface

// File: rtl/mem_bus_if.sv
// Memory-stage bus interface: zero-latency scratchpad path plus a shared-bus
// master with request/grant handshake, access timeout and stall hold buffer.
module mem_bus_if
  import mem_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  input  logic [29:0] addr,
  input  logic        as_,
  input  logic        rw,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [31:0] spm_rd_data,
  output logic [29:0] spm_addr,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [31:0] spm_wr_data,
  mem_bus_if_if.master bus,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  bus_state_t  state, state_nx;
  logic [7:0]  cnt;
  logic [31:0] rd_buf;
  logic        start;
  logic        xfer_end;
  logic [31:0] end_data;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    rd_data  = '0;
    spm_as_  = DISABLE_;
    bus_err  = 1'b0;
    start    = 1'b0;
    xfer_end = 1'b0;
    end_data = '0;
    case (state)
      ST_IDLE: begin
        if (!flush && as_ == ENABLE_) begin
          if (spm_hit(addr)) begin
            spm_as_ = ENABLE_;
            rd_data = spm_rd_data;
          end else begin
            busy     = 1'b1;
            start    = 1'b1;
            state_nx = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        busy = 1'b1;
        if (bus.bus_grnt_ == ENABLE_) state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (bus.bus_rdy_ == ENABLE_) begin
          xfer_end = 1'b1;
          end_data = (bus.bus_rw == READ) ? bus.bus_rd_data : '0;
          rd_data  = end_data;
          state_nx = stall ? ST_STALL : ST_IDLE;
        end else if (cnt == TIMEOUT_CNT) begin
          xfer_end = 1'b1;
          bus_err  = 1'b1;
          state_nx = stall ? ST_STALL : ST_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      ST_STALL: begin
        rd_data = rd_buf;
        if (!stall) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bus.bus_req_    <= DISABLE_;
      bus.bus_as_     <= DISABLE_;
      bus.bus_rw      <= READ;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
      rd_buf          <= '0;
      cnt             <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        bus.bus_req_    <= ENABLE_;
        bus.bus_addr    <= addr;
        bus.bus_rw      <= rw;
        bus.bus_wr_data <= wr_data;
      end
      if (xfer_end) begin
        bus.bus_req_ <= DISABLE_;
        rd_buf       <= end_data;
      end
      // Address strobe is a single-cycle pulse in the first ACCESS cycle.
      bus.bus_as_ <= (state == ST_REQ && bus.bus_grnt_ == ENABLE_) ? ENABLE_ : DISABLE_;
      if (state == ST_REQ) begin
        cnt <= '0;
      end else if (state == ST_ACCESS && bus.bus_rdy_ != ENABLE_) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed and randomized bench for mem_bus_if; expectations come from a
// transaction-level model (grant delay, ready delay, stall length).
module tb_mem_bus_if;
  import mem_bus_if_pkg::*;

  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy, as_, rw, spm_as_, spm_rw, bus_err;
  logic [29:0] addr, spm_addr;
  logic [31:0] wr_data, rd_data, spm_rd_data, spm_wr_data;
  int          tests = 0;
  int          fails = 0;

  mem_bus_if_if bus_if();

  mem_bus_if #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .busy        (busy),
    .addr        (addr),
    .as_         (as_),
    .rw          (rw),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .spm_rd_data (spm_rd_data),
    .spm_addr    (spm_addr),
    .spm_as_     (spm_as_),
    .spm_rw      (spm_rw),
    .spm_wr_data (spm_wr_data),
    .bus         (bus_if.master),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  function automatic logic [29:0] miss_addr();
    logic [2:0] tag;
    tag = 3'($urandom_range(0, 6));
    if (tag >= 3'd3) tag = tag + 3'd1;
    return {tag, 27'($urandom)};
  endfunction

  task automatic spm_access(input logic [29:0] a, input logic [31:0] d);
    logic        r;
    logic [31:0] w;
    r = 1'($urandom);
    w = $urandom;
    addr = a; as_ = ENABLE_; rw = r; wr_data = w; spm_rd_data = d;
    settle;
    chk("spm_rd_data", rd_data, d);
    chk("spm_busy", busy, 0);
    chk("spm_as", spm_as_, ENABLE_);
    chk("spm_bus_req", bus_if.bus_req_, DISABLE_);
    chk("spm_addr_copy", spm_addr, a);
    chk("spm_rw_copy", spm_rw, r);
    chk("spm_wd_copy", spm_wr_data, w);
    step;
    as_ = DISABLE_;
    settle;
    chk("spm_after_req", bus_if.bus_req_, DISABLE_);
    step;
  endtask

  task automatic bus_xfer(input logic [29:0] a, input logic r_w, input logic [31:0] wd,
                          input logic [31:0] rdat, input int unsigned g, input int unsigned r,
                          input int unsigned s);
    int unsigned busy_cnt, as_cnt, endj;
    logic        to;
    logic [31:0] exp_rd;
    busy_cnt = 0;
    as_cnt   = 0;
    to       = (r > TO);
    endj     = to ? TO : r;
    exp_rd   = (to || r_w == WRITE) ? 32'h0 : rdat;

    addr = a; rw = r_w; wr_data = wd; as_ = ENABLE_;
    settle;
    chk("issue_busy", busy, 1);
    chk("issue_spm_as", spm_as_, DISABLE_);
    chk("issue_req_idle", bus_if.bus_req_, DISABLE_);
    if (busy) busy_cnt++;
    step;
    as_ = DISABLE_; addr = $urandom; wr_data = $urandom; rw = 1'($urandom);

    for (int unsigned k = 0; k <= g; k++) begin
      bus_if.bus_grnt_ = (k == g) ? ENABLE_ : DISABLE_;
      settle;
      if (busy) busy_cnt++;
      if (bus_if.bus_as_ == ENABLE_) as_cnt++;
      chk("req_busy", busy, 1);
      chk("req_bus_req", bus_if.bus_req_, ENABLE_);
      chk("req_bus_addr", bus_if.bus_addr, a);
      chk("req_bus_rw", bus_if.bus_rw, r_w);
      chk("req_bus_wd", bus_if.bus_wr_data, wd);
      step;
    end
    bus_if.bus_grnt_ = DISABLE_;

    for (int unsigned j = 0; j <= endj; j++) begin
      bus_if.bus_rdy_     = (j == endj && !to) ? ENABLE_ : DISABLE_;
      bus_if.bus_rd_data  = (j == endj) ? rdat : $urandom;
      stall               = (j == endj && s > 0);
      settle;
      if (busy) busy_cnt++;
      if (bus_if.bus_as_ == ENABLE_) as_cnt++;
      chk("acc_bus_as", bus_if.bus_as_, (j == 0) ? ENABLE_ : DISABLE_);
      chk("acc_bus_req", bus_if.bus_req_, ENABLE_);
      if (j < endj) begin
        chk("acc_busy", busy, 1);
        chk("acc_no_err", bus_err, 0);
      end else begin
        chk("done_busy", busy, 0);
        chk("done_bus_err", bus_err, to);
        chk("done_rd_data", rd_data, exp_rd);
      end
      step;
    end
    bus_if.bus_rdy_    = DISABLE_;
    bus_if.bus_rd_data = $urandom;
    chk("busy_cycles", busy_cnt, 1 + (g + 1) + endj);
    chk("as_pulse_cycles", as_cnt, 1);

    for (int unsigned t = 0; t < s; t++) begin
      stall = (t + 1 < s);
      settle;
      chk("stall_busy", busy, 0);
      chk("stall_bus_req", bus_if.bus_req_, DISABLE_);
      chk("stall_bus_as", bus_if.bus_as_, DISABLE_);
      chk("stall_rd_data", rd_data, exp_rd);
      chk("stall_no_err", bus_err, 0);
      step;
    end
    stall = 1'b0;
    settle;
    chk("end_idle_busy", busy, 0);
    chk("end_idle_req", bus_if.bus_req_, DISABLE_);
    chk("end_idle_rd", rd_data, 0);
    step;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = DISABLE_; rw = READ;
    addr = '0; wr_data = '0; spm_rd_data = '0;
    bus_if.bus_grnt_ = DISABLE_; bus_if.bus_rdy_ = DISABLE_; bus_if.bus_rd_data = '0;
    step;
    step;
    settle;
    chk("rst_bus_req", bus_if.bus_req_, DISABLE_);
    chk("rst_bus_as", bus_if.bus_as_, DISABLE_);
    chk("rst_bus_rw", bus_if.bus_rw, READ);
    chk("rst_bus_addr", bus_if.bus_addr, 0);
    chk("rst_bus_wd", bus_if.bus_wr_data, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step;

    spm_access(30'h1800_0004, 32'hCAFE_0001);
    bus_xfer(30'h0000_0010, READ, 32'h0, 32'h1234_5678, 1, 3, 0);
    bus_xfer(miss_addr(), WRITE, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 1, 4);

    // Timeout: grant given, ready never arrives.
    bus_xfer(miss_addr(), READ, 32'h0, 32'h7777_7777, 0, TO + 1, 0);
    bus_xfer(miss_addr(), READ, 32'h0, 32'h3333_1111, 2, TO + 1, 2);

    // Ready coincides with the timeout cycle: ready wins.
    bus_xfer(miss_addr(), READ, 32'h0, 32'hA5A5_0F0F, 0, TO, 0);

    // Flush in IDLE with a pending strobe (hit and miss address).
    for (int i = 0; i < 2; i++) begin
      addr = (i == 0) ? 30'h1800_0100 : miss_addr();
      as_ = ENABLE_; flush = 1'b1; spm_rd_data = 32'hFFFF_FFFF;
      settle;
      chk("flush_spm_as", spm_as_, DISABLE_);
      chk("flush_busy", busy, 0);
      chk("flush_rd", rd_data, 0);
      step;
      as_ = DISABLE_; flush = 1'b0;
      settle;
      chk("flush_bus_req", bus_if.bus_req_, DISABLE_);
      chk("flush_bus_as", bus_if.bus_as_, DISABLE_);
      step;
    end

    // Reset in the middle of ACCESS.
    addr = miss_addr(); rw = READ; as_ = ENABLE_;
    step;
    as_ = DISABLE_; bus_if.bus_grnt_ = ENABLE_;
    step;
    bus_if.bus_grnt_ = DISABLE_;
    settle;
    chk("pre_rst_as", bus_if.bus_as_, ENABLE_);
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    settle;
    chk("mid_rst_bus_req", bus_if.bus_req_, DISABLE_);
    chk("mid_rst_bus_as", bus_if.bus_as_, DISABLE_);
    chk("mid_rst_bus_err", bus_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bus_addr", bus_if.bus_addr, 0);
    step;

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0)
        spm_access({SPM_ADDR_TAG, 27'($urandom)}, $urandom);
      else
        bus_xfer(miss_addr(), 1'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 Parameter TIMEOUT, 255, max cycles in ACCESS waiting for bus_rdy_ before abort; 8-bit counter.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  pipeline stall; holds completed result.
REQ-005 flush  input  1  pipeline flush; suppresses new access in IDLE.
REQ-006 busy  output  1  access in progress; pipeline must stall.
REQ-007 addr  input  30  word address from memory-access stage.
REQ-008 as_  input  1  address strobe, active-low.
REQ-009 rw  input  1  1=READ, 0=WRITE.
REQ-010 wr_data  input  32  store data.
REQ-011 rd_data  output  32  load data returned to memory-access stage.
REQ-012 spm_rd_data  input  32; spm_addr output 30; spm_as_ output 1; spm_rw output 1; spm_wr_data output 32 (scratchpad port).
REQ-013 bus_rd_data input 32; bus_rdy_ input 1; bus_grnt_ input 1; bus_req_ output 1; bus_addr output 30; bus_as_ output 1; bus_rw output 1; bus_wr_data output 32 (shared-bus master port; strobes active-low).
REQ-014 bus_err  output  1  one-cycle pulse on bus timeout.

Function
REQ-015 spm_addr/spm_rw/spm_wr_data SHALL be combinational copies of addr/rw/wr_data.
REQ-016 SPM hit = addr[29:27]==SPM_ADDR_TAG (3'b011).
REQ-017 States: IDLE, REQ, ACCESS, STALL.
REQ-018 IDLE, flush=1: no strobe asserted, rd_data=0, busy=0, stay IDLE.
REQ-019 IDLE, as_=0, SPM hit: spm_as_=0 same cycle, rd_data=spm_rd_data, busy=0, stay IDLE (zero-latency).
REQ-020 IDLE, as_=0, no hit: register addr/rw/wr_data into bus_addr/bus_rw/bus_wr_data, bus_req_=0 from next edge, busy=1 combinationally, go REQ.
REQ-021 REQ: hold bus_req_=0, busy=1; on bus_grnt_=0 drive bus_as_=0 for exactly next cycle, clear timeout counter, go ACCESS.
REQ-022 ACCESS: bus_req_ held; bus_as_=1 after first ACCESS cycle; counter increments each cycle without bus_rdy_.
REQ-023 ACCESS with bus_rdy_=0: busy=0 that cycle, rd_data=bus_rd_data (0 for write), capture into rd_buf, release bus_req_ at edge; go STALL if stall=1 else IDLE.
REQ-024 ACCESS with counter==TIMEOUT and bus_rdy_=1: bus_err=1 one cycle, busy=0, rd_data=0, rd_buf=0, release bus_req_; go STALL if stall=1 else IDLE.
REQ-025 bus_rdy_=0 and timeout in same cycle: bus_rdy_ wins, no bus_err.
REQ-026 STALL: busy=0, rd_data=rd_buf, no strobes; go IDLE when stall=0.
REQ-027 flush in REQ/ACCESS SHALL be ignored; issued bus access always completes.
REQ-028 bus_req_ SHALL be high in every IDLE and STALL cycle.

Reset
REQ-029 reset=1 at edge: state=IDLE, bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0, bus_wr_data=0, rd_buf=0, counter=0, bus_err=0.
REQ-030 Reset mid-REQ/ACCESS: abandon transaction, bus released at that edge, no bus_err.

Structure
REQ-031 State encoding, SPM_ADDR_TAG, address-tag bit range and READ/WRITE, ENABLE_/DISABLE_ constants SHALL live in the shared CPU/bus headers.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 SPM read addr=30'h1800_0004, as_=0, spm_rd_data=32'hCAFE_0001 -> rd_data=32'hCAFE_0001 same cycle, busy=0, bus_req_=1.
REQ-034 Bus read addr=30'h0000_0010, grant after 2 cycles, rdy after 3 -> busy=1 for 6 cycles, bus_as_ low exactly 1 cycle, rd_data=bus_rd_data=32'h1234_5678 on rdy cycle.
REQ-035 Bus write with stall=1 held 4 cycles after rdy -> STALL 4 cycles, busy=0, bus_req_=1, return IDLE when stall=0.
REQ-036 Grant given, bus_rdy_ never asserted -> bus_err pulse after 255 ACCESS cycles, rd_data=0, bus_req_=1 next cycle.
REQ-037 reset asserted in ACCESS -> next cycle IDLE, bus_req_=1, bus_as_=1, bus_err=0; flush=1 with as_=0 in IDLE -> no strobe on either port.
